// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like bus port between instruction fetch and the data stage.
// Optional round-robin arbitration is enabled by defining MEM_ARB_FAIR_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_inst_req,
  input  logic [ADDR_W-1:0]     i_inst_addr,
  output logic [DATA_W-1:0]     o_inst_rdata,
  output logic                  o_inst_done,
  output logic                  o_inst_stall,
  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [DATA_W/8-1:0]   i_data_sel,
  input  logic [ADDR_W-1:0]     i_data_addr,
  input  logic [DATA_W-1:0]     i_data_wdata,
  output logic [DATA_W-1:0]     o_data_rdata,
  output logic                  o_data_done,
  output logic                  o_data_stall,
  output logic                  o_bus_req,
  output logic                  o_bus_wr,
  output logic [DATA_W/8-1:0]   o_bus_wstrb,
  output logic [ADDR_W-1:0]     o_bus_addr,
  output logic [DATA_W-1:0]     o_bus_wdata,
  input  logic                  i_bus_addr_ok,
  input  logic [DATA_W-1:0]     i_bus_rdata,
  input  logic                  i_bus_data_ok,
  output logic [1:0]            o_state
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner_data;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [STRB_W-1:0]   r_strb;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_inst_rdata;
  logic [DATA_W-1:0]   r_data_rdata;
  logic                w_any_req;
  logic                w_grant;
  logic                w_grant_data;
  logic                w_capture;

  assign w_any_req = i_inst_req | i_data_req;
  assign w_grant   = (r_state == S_IDLE) && w_any_req;
  assign w_capture = (r_state == S_WAIT) && i_bus_data_ok && !r_we;

`ifdef MEM_ARB_FAIR_EN
  // Remembers which requester won the previous grant; resets as inst-last so data wins the first tie.
  logic r_last_inst;

  assign w_grant_data = i_data_req & (~i_inst_req | r_last_inst);

  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_last_inst <= 1'b1;
    end else if (w_grant) begin
      r_last_inst <= ~w_grant_data;
    end
  end
`else
  assign w_grant_data = i_data_req;
`endif

  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_any_req) w_next_state = S_ADDR;
      S_ADDR: if (i_bus_addr_ok) w_next_state = S_WAIT;
      S_WAIT: if (i_bus_data_ok) w_next_state = S_RESP;
      S_RESP: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_bus_req   = 1'b0;
    o_inst_done = 1'b0;
    o_data_done = 1'b0;
    case (r_state)
      S_ADDR: o_bus_req = 1'b1;
      S_RESP: begin
        o_inst_done = ~r_owner_data;
        o_data_done = r_owner_data;
      end
      default: ;
    endcase
  end

  // Request fields are latched at grant so the requester's inputs are free to move afterwards.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_owner_data <= 1'b0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_strb       <= '0;
      r_wdata      <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner_data <= w_grant_data;
        r_addr       <= w_grant_data ? i_data_addr : i_inst_addr;
        r_we         <= w_grant_data & i_data_we;
        r_strb       <= (w_grant_data & i_data_we) ? i_data_sel : '0;
        r_wdata      <= w_grant_data ? i_data_wdata : '0;
      end
      if (w_capture) begin
        if (r_owner_data) r_data_rdata <= i_bus_rdata;
        else              r_inst_rdata <= i_bus_rdata;
      end
    end
  end

  assign o_bus_wr     = r_we;
  assign o_bus_wstrb  = r_strb;
  assign o_bus_addr   = r_addr;
  assign o_bus_wdata  = r_wdata;
  assign o_inst_rdata = r_inst_rdata;
  assign o_data_rdata = r_data_rdata;
  assign o_inst_stall = i_inst_req & ~o_inst_done;
  assign o_data_stall = i_data_req & ~o_data_done;
  assign o_state      = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus
// hand-written sequences for stray handshakes, mid-access reset and arbitration.
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_inst_req = 1'b0;
  logic [31:0] i_inst_addr = '0;
  logic [31:0] o_inst_rdata;
  logic        o_inst_done;
  logic        o_inst_stall;
  logic        i_data_req = 1'b0;
  logic        i_data_we = 1'b0;
  logic [3:0]  i_data_sel = '0;
  logic [31:0] i_data_addr = '0;
  logic [31:0] i_data_wdata = '0;
  logic [31:0] o_data_rdata;
  logic        o_data_done;
  logic        o_data_stall;
  logic        o_bus_req;
  logic        o_bus_wr;
  logic [3:0]  o_bus_wstrb;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic        i_bus_addr_ok = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        i_bus_data_ok = 1'b0;
  logic [1:0]  o_state;

  int total = 0;
  int bad = 0;

  // Bus responder controls: automatic delays when enabled, manual levels otherwise.
  logic        g_resp_en = 1'b1;
  int          g_addr_delay = 0;
  int          g_data_delay = 0;
  logic [31:0] g_rdata = '0;
  logic        m_addr_ok = 1'b0;
  logic        m_data_ok = 1'b0;
  logic [31:0] m_rdata = '0;

  mem_port_arbiter dut (
    .i_clk(i_clk), .rst(rst),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr),
    .o_inst_rdata(o_inst_rdata), .o_inst_done(o_inst_done), .o_inst_stall(o_inst_stall),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_sel(i_data_sel),
    .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
    .o_data_rdata(o_data_rdata), .o_data_done(o_data_done), .o_data_stall(o_data_stall),
    .o_bus_req(o_bus_req), .o_bus_wr(o_bus_wr), .o_bus_wstrb(o_bus_wstrb),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_addr_ok(i_bus_addr_ok), .i_bus_rdata(i_bus_rdata), .i_bus_data_ok(i_bus_data_ok),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  // Responder runs #2 after the edge so the main sequence's #1 updates are visible.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    forever begin
      @(posedge i_clk);
      #2;
      if (!g_resp_en || rst) begin
        phase = 0;
        cnt = 0;
        i_bus_addr_ok = g_resp_en ? 1'b0 : m_addr_ok;
        i_bus_data_ok = g_resp_en ? 1'b0 : m_data_ok;
        i_bus_rdata   = g_resp_en ? i_bus_rdata : m_rdata;
      end else begin
        i_bus_addr_ok = 1'b0;
        i_bus_data_ok = 1'b0;
        if (phase == 0 && o_bus_req) begin
          if (cnt == g_addr_delay) begin
            i_bus_addr_ok = 1'b1;
            phase = 1;
            cnt = 0;
          end else cnt++;
        end else if (phase == 1) begin
          if (cnt == g_data_delay) begin
            i_bus_data_ok = 1'b1;
            i_bus_rdata = g_rdata;
            phase = 0;
            cnt = 0;
          end else cnt++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic        is_data;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          ad;
    int          dd;
    logic [3:0]  exp_wstrb;
    int          exp_cycle;
    logic [31:0] exp_inst_rd;
    logic [31:0] exp_data_rd;
  } vec_t;

  // Starts in an IDLE cycle (cycle 0) and returns in the IDLE cycle after done.
  task automatic run_vec(input vec_t v, input int idx);
    int   c;
    logic seen;
    logic bus_bad;
    logic done;
    logic stall;
    g_addr_delay = v.ad;
    g_data_delay = v.dd;
    g_rdata = v.bus_rdata;
    if (v.is_data) begin
      i_data_req = 1'b1;
      i_data_we = v.we;
      i_data_sel = v.sel;
      i_data_addr = v.addr;
      i_data_wdata = v.wdata;
    end else begin
      i_inst_req = 1'b1;
      i_inst_addr = v.addr;
    end
    c = 0;
    seen = 1'b0;
    bus_bad = 1'b0;
    while (!seen && c < 40) begin
      step();
      c++;
      done  = v.is_data ? o_data_done : o_inst_done;
      stall = v.is_data ? o_data_stall : o_inst_stall;
      if (o_bus_req && (o_bus_addr !== v.addr || o_bus_wr !== (v.is_data & v.we) ||
          o_bus_wstrb !== v.exp_wstrb || (v.is_data && v.we && o_bus_wdata !== v.wdata)))
        bus_bad = 1'b1;
      if (stall !== ~done) bus_bad = 1'b1;
      if (done) seen = 1'b1;
    end
    i_data_req = 1'b0;
    i_inst_req = 1'b0;
    check($sformatf("v%0d done_cycle", idx), 32'(c), 32'(v.exp_cycle));
    check($sformatf("v%0d bus_fields_stall", idx), {31'd0, bus_bad}, 32'd0);
    check($sformatf("v%0d inst_rdata", idx), o_inst_rdata, v.exp_inst_rd);
    check($sformatf("v%0d data_rdata", idx), o_data_rdata, v.exp_data_rd);
    step();
    check($sformatf("v%0d back_idle", idx), {28'd0, o_state, o_inst_done, o_data_done}, 32'd0);
  endtask

  vec_t vecs[6];
  logic exp_own[3];
  logic [31:0] exp_arb_addr[3];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'b0000, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 4'b0000, 3,
                32'h0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h1111_1111, 0, 0, 4'b0100, 3,
                32'h0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 4'b0000, 32'hBFC0_0000, 32'h0, 32'h3C08_0001, 1, 0, 4'b0000, 4,
                32'h3C08_0001, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 4'b0000, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 3, 2, 4'b0000, 8,
                32'h3C08_0001, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1'b1, 4'b1111, 32'h0000_3000, 32'h1234_5678, 32'h2222_2222, 0, 1, 4'b1111, 4,
                32'h3C08_0001, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 1'b0, 4'b0000, 32'hBFC0_0004, 32'h0, 32'h2409_0002, 2, 1, 4'b0000, 6,
                32'h2409_0002, 32'hCAFE_F00D};
`ifdef MEM_ARB_FAIR_EN
    exp_own[0] = 1'b1; exp_own[1] = 1'b0; exp_own[2] = 1'b1;
    exp_arb_addr[0] = 32'h8000; exp_arb_addr[1] = 32'hBFC0_0000; exp_arb_addr[2] = 32'h8000;
`else
    exp_own[0] = 1'b1; exp_own[1] = 1'b1; exp_own[2] = 1'b1;
    exp_arb_addr[0] = 32'h8000; exp_arb_addr[1] = 32'h8000; exp_arb_addr[2] = 32'h8000;
`endif

    // Reset block
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("reset state", {30'd0, o_state}, 32'd0);
    check("reset bus_req_wr", {30'd0, o_bus_req, o_bus_wr}, 32'd0);
    check("reset wstrb", {28'd0, o_bus_wstrb}, 32'd0);
    check("reset bus_addr", o_bus_addr, 32'd0);
    check("reset bus_wdata", o_bus_wdata, 32'd0);
    check("reset rdata", o_inst_rdata | o_data_rdata, 32'd0);
    check("reset done", {30'd0, o_inst_done, o_data_done}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // data_ok during ADDR must be ignored
    g_resp_en = 1'b0;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h5000;
    step();
    m_data_ok = 1'b1; m_rdata = 32'h0BAD_F00D;
    step();
    check("stray ok state", {30'd0, o_state}, 32'd1);
    check("stray ok bus_req", {31'd0, o_bus_req}, 32'd1);
    m_data_ok = 1'b0; m_addr_ok = 1'b1;
    step();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h600D_CAFE;
    step();
    m_data_ok = 1'b0;
    check("stray ok done", {31'd0, o_data_done}, 32'd1);
    check("stray ok rdata", o_data_rdata, 32'h600D_CAFE);
    i_data_req = 1'b0;
    step();

    // Reset while WAIT, then a late data_ok
    i_data_req = 1'b1; i_data_addr = 32'h7000;
    step();
    m_addr_ok = 1'b1;
    step();
    m_addr_ok = 1'b0;
    check("rst_mid in wait", {30'd0, o_state}, 32'd2);
    rst = 1'b1; i_data_req = 1'b0;
    step();
    rst = 1'b0;
    m_data_ok = 1'b1; m_rdata = 32'h55AA_55AA;
    check("rst_mid state", {30'd0, o_state}, 32'd0);
    check("rst_mid bus", {o_bus_req, o_bus_wr, o_bus_wstrb, 26'd0}, 32'd0);
    check("rst_mid bus_addr", o_bus_addr, 32'd0);
    check("rst_mid rdata", o_data_rdata | o_inst_rdata, 32'd0);
    begin
      logic quiet;
      quiet = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        m_data_ok = 1'b0;
        if (o_data_done || o_inst_done || o_state != 2'd0 || o_data_rdata != 32'd0) quiet = 1'b0;
      end
      check("rst_mid no done", {31'd0, quiet}, 32'd1);
    end

    // Both requesters held high for three accesses
    g_resp_en = 1'b1;
    g_addr_delay = 0; g_data_delay = 0; g_rdata = 32'hA000_0000;
    i_inst_req = 1'b1; i_inst_addr = 32'hBFC0_0000;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h8000;
    begin
      logic        stall_bad;
      stall_bad = 1'b0;
      for (int k = 0; k < 3; k++) begin
        logic        found;
        int          n;
        logic [31:0] last_addr;
        found = 1'b0;
        n = 0;
        last_addr = '0;
        while (!found && n < 30) begin
          step();
          n++;
          if (o_bus_req) last_addr = o_bus_addr;
          if (o_inst_stall !== (i_inst_req & ~o_inst_done)) stall_bad = 1'b1;
          if (o_data_stall !== (i_data_req & ~o_data_done)) stall_bad = 1'b1;
          if (o_inst_done || o_data_done) found = 1'b1;
        end
        check($sformatf("arb%0d done seen", k), {31'd0, found}, 32'd1);
        check($sformatf("arb%0d owner", k), {31'd0, o_data_done}, {31'd0, exp_own[k]});
        check($sformatf("arb%0d bus_addr", k), last_addr, exp_arb_addr[k]);
        check($sformatf("arb%0d rdata", k), exp_own[k] ? o_data_rdata : o_inst_rdata, g_rdata);
        g_rdata = g_rdata + 32'd1;
        if (k == 2) begin
          i_inst_req = 1'b0;
          i_data_req = 1'b0;
        end
      end
      check("arb stall", {31'd0, stall_bad}, 32'd0);
    end
    step();
    check("arb end idle", {28'd0, o_state, o_inst_stall, o_data_stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
